// File: rtl/mac_array_sequencer.sv
// Phase controller for the systolic mac_array: clear, skewed load, skewed compute
// window and skewed drain wavefronts, followed by a one-cycle done pulse.
module mac_array_sequencer #(
  parameter int N_MACS = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  k_len,
  input  logic [N_MACS-1:0] active_mask,
  input  logic              clear_en,
  output logic [N_MACS-1:0] valid_ctrl_0,
  output logic [N_MACS-1:0] valid_ctrl_1,
  output logic [N_MACS-1:0] valid_ctrl_2,
  output logic [N_MACS-1:0] clear_ctrl,
  output logic              a_rd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [LEN_W:0] LANES = (LEN_W+1)'(N_MACS);

  state_t             r_state;
  logic [LEN_W:0]     r_cnt;
  logic [LEN_W-1:0]   r_klen;
  logic [N_MACS-1:0]  r_mask;
  logic               r_clr;

  logic [LEN_W:0]     w_cntNext;
  logic [LEN_W:0]     w_klenExt;
  logic [LEN_W:0]     w_compLen;

  // One extra counter bit so k_len + N_MACS - 1 never wraps.
  assign w_cntNext = r_cnt + (LEN_W+1)'(1);
  assign w_klenExt = {1'b0, r_klen};
  assign w_compLen = w_klenExt + LANES - (LEN_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
      r_mask  <= '0;
      r_clr   <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start && !abort) begin
            r_klen  <= k_len;
            r_mask  <= active_mask;
            r_clr   <= clear_en;
            r_state <= clear_en ? S_CLEAR : S_LOAD;
          end
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_cntNext == LANES) begin
            r_cnt   <= '0;
            r_state <= (r_klen != '0) ? S_COMPUTE : S_DRAIN;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        S_COMPUTE: begin
          if (w_cntNext == w_compLen) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        S_DRAIN: begin
          if (w_cntNext == LANES) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane i of the compute window trails lane 0 by i cycles, matching array propagation.
  always_comb begin
    valid_ctrl_0 = '0;
    valid_ctrl_1 = '0;
    valid_ctrl_2 = '0;
    clear_ctrl   = '0;
    busy = (r_state == S_CLEAR) || (r_state == S_LOAD) ||
           (r_state == S_COMPUTE) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
    a_rd = (r_state == S_COMPUTE) && (r_cnt < w_klenExt);
    for (int i = 0; i < N_MACS; i++) begin
      clear_ctrl[i]   = (r_state == S_CLEAR) && r_mask[i];
      valid_ctrl_0[i] = (r_state == S_LOAD) && (r_cnt == (LEN_W+1)'(i)) && r_mask[i];
      valid_ctrl_1[i] = (r_state == S_COMPUTE) && (r_cnt >= (LEN_W+1)'(i)) &&
                        (r_cnt < w_klenExt + (LEN_W+1)'(i)) && r_mask[i];
      valid_ctrl_2[i] = (r_state == S_DRAIN) && (r_cnt == (LEN_W+1)'(i)) && r_mask[i];
    end
  end

endmodule

// File: doc/mac_array_sequencer.md
Name: mac_array_sequencer

Overview:
- Phase controller for the 4-lane systolic mac_array.
- On a start pulse it runs one job through the following phases, then pulses done:
  - optional accumulator clear;
  - skewed load wavefront on valid_in_0;
  - skewed compute window of k_len samples on valid_in_1;
  - skewed drain wavefront on valid_in_2.
- It sits between the host/top-level control and the array's valid_in_0/1/2 and clear ports, replacing the single-purpose loading FSM.

Parameters:
- N_MACS, 4, number of MAC lanes; width of every per-lane control vector.
- LEN_W, 8, width of k_len and of the internal phase counter (counter is LEN_W+1 bits).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current job.
- k_len  in  LEN_W  number of compute samples; latched at start acceptance.
- active_mask  in  N_MACS  lanes taking part in the job; latched at start acceptance.
- clear_en  in  1  run the CLEAR phase first; latched at start acceptance.
- valid_ctrl_0  out  N_MACS  to mac_array valid_in_0 (load phase).
- valid_ctrl_1  out  N_MACS  to mac_array valid_in_1 (compute phase).
- valid_ctrl_2  out  N_MACS  to mac_array valid_in_2 (drain phase).
- clear_ctrl  out  N_MACS  to mac_array clear.
- a_rd  out  1  upstream must present the next a_in sample this cycle.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, latched registers=0.
  - All outputs are 0 while reset is asserted and in the first cycle after release.
- States: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE. The counter cnt resets to 0 on every state entry.
- Outputs are decoded from the registered state, cnt and latched inputs. Every per-lane output is ANDed with the latched mask m.
- IDLE:
  - All outputs 0.
  - start=1 at an edge latches k_len, m and clear_en, then moves to CLEAR if clear_en=1, else LOAD.
  - The first phase cycle is the cycle after start is sampled.
- CLEAR: 1 cycle; clear_ctrl=m; then LOAD.
- LOAD: N_MACS cycles; at cnt=i, valid_ctrl_0 = one-hot bit i & m.
  - After cnt=N_MACS-1 the next state is COMPUTE if k_len>0, else DRAIN.
- COMPUTE: k_len+N_MACS-1 cycles.
  - Lane i asserts valid_ctrl_1[i] for cnt in [i, i+k_len-1] (one-cycle skew per lane, matching array propagation).
  - a_rd=1 for cnt in [0, k_len-1] regardless of mask.
  - Then DRAIN.
- DRAIN: N_MACS cycles; at cnt=i, valid_ctrl_2 = one-hot bit i & m; then DONE.
- DONE: 1 cycle; done=1, busy=0; then IDLE. A start sampled in DONE is ignored.
- busy = 1 in CLEAR, LOAD, COMPUTE and DRAIN.
- start while busy: ignored; nothing queued.
- abort=1 in any non-IDLE state:
  - next state IDLE; no done pulse; all outputs 0 from the next cycle.
  - abort has priority over normal transitions.
  - abort and start together in IDLE: start is ignored.
- k_len=0: COMPUTE is skipped entirely; a_rd is never asserted.
- m=0: the full state sequence and timing still run, all per-lane outputs stay 0, and done still pulses.
- Changes to k_len, active_mask or clear_en during a job have no effect.
- Counter must cover the maximum k_len of 2^LEN_W-1 plus N_MACS-1 without overflow.
- busy cycles per job = clear_en + N_MACS + (k_len>0 ? k_len+N_MACS-1 : 0) + N_MACS.
- Reset asserted mid-job: immediate return to IDLE, outputs 0, no done.

Test Plan:
- Reset, then start with k_len=3, m=4'b1111, clear_en=1 ->
  - clear_ctrl=1111 in cycle 1;
  - valid_ctrl_0 = 0001, 0010, 0100, 1000 in cycles 2–5;
  - valid_ctrl_1 = 0001, 0011, 0111, 1110, 1100, 1000 in cycles 6–11;
  - a_rd high in cycles 6–8;
  - valid_ctrl_2 one-hot walk in cycles 12–15;
  - done in cycle 16; busy high for exactly 15 cycles.
- m=4'b0011, k_len=1, clear_en=0, with the array loaded with w_0=2, w_1=3 and a_in=10 -> only bits 0/1 ever toggle; acc_out_0=20 and acc_out_1=30 after done.
- k_len=0, clear_en=0 -> LOAD (4 cycles) is followed directly by DRAIN (4 cycles); a_rd stays 0; done in cycle 9.
- abort asserted in the 3rd COMPUTE cycle -> all outputs 0 and busy=0 the next cycle; no done pulse; a new start is accepted afterwards.
- start pulsed again mid-job, and k_len changed to 7 mid-job -> the job timing is unchanged and no second job runs.
- rst driven low asynchronously between clock edges during LOAD -> outputs drop to 0 immediately; after release the block is in IDLE with busy=0.
